fetch_stage_p: RTL and testbench
================================

FETCH_STAGE_P -- requirements
Module: fetch_stage_p

Interface
REQ-001 Parameter DW, default 16, instruction width in bits.
REQ-002 Parameter AW, default 16, PC and instruction-memory address width.
REQ-003 Parameter STEP, default 1, PC increment per sequential fetch (word-addressed memory).
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 Parameter CNT_W, default 16, width of the performance counters.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 stall_d  in  1  decode cannot accept; hold IF/ID contents.
REQ-009 redirect_e  in  1  taken branch/jump resolved in execute.
REQ-010 target_e  in  AW  redirect destination PC.
REQ-011 imem_addr  out  AW  synchronous instruction-memory read address (combinational).
REQ-012 imem_rdata  in  DW  read data; corresponds to the address presented the previous cycle.
REQ-013 instr_d  out  DW  IF/ID instruction.
REQ-014 pc_d  out  AW  IF/ID PC of instr_d.
REQ-015 pc_plus_d  out  AW  IF/ID pc_d+STEP.
REQ-016 valid_d  out  1  IF/ID contents are a real instruction.
REQ-017 fetch_cnt  out  CNT_W  instructions delivered to decode.
REQ-018 flush_cnt  out  CNT_W  redirects taken.

Function
REQ-019 Internal state: pc_f (next address to issue), pc_req/req_valid (in-flight request), skid_instr/skid_pc/skid_valid, FSM {BOOT, RUN, STALL}.
REQ-020 imem_addr SHALL equal target_e when redirect_e=1, else pc_f.
REQ-021 Priority: redirect_e over stall_d in every state.
REQ-022 Redirect (any state): valid_d<=0, skid_valid<=0, pc_req<=target_e, req_valid<=1, pc_f<=target_e+STEP, flush_cnt+=1, state<=RUN; in-flight imem_rdata discarded.
REQ-023 BOOT (no redirect, stall ignored): pc_req<=pc_f, req_valid<=1, pc_f<=pc_f+STEP, valid_d stays 0, state<=RUN.
REQ-024 RUN, stall_d=0: IF/ID<={imem_rdata, pc_req, pc_req+STEP}, valid_d<=req_valid; pc_req<=pc_f, req_valid<=1, pc_f<=pc_f+STEP.
REQ-025 RUN, stall_d=1: IF/ID held; skid<={imem_rdata, pc_req}, skid_valid<=req_valid; req_valid<=0; pc_f held; state<=STALL.
REQ-026 STALL, stall_d=1: all registers held; imem_rdata ignored.
REQ-027 STALL, stall_d=0: IF/ID<={skid_instr, skid_pc, skid_pc+STEP}, valid_d<=skid_valid; skid_valid<=0; pc_req<=pc_f, req_valid<=1, pc_f<=pc_f+STEP; state<=RUN.
REQ-028 No instruction SHALL be lost or duplicated across any stall pattern, including single-cycle stalls and back-to-back stalls.
REQ-029 All PC arithmetic modulo 2^AW; wrap from 2^AW-STEP to 0 without fault.
REQ-030 fetch_cnt increments on each edge where valid_d is loaded with 1 and IF/ID is updated; flush_cnt per REQ-022; both saturate at 2^CNT_W-1.
REQ-031 Redirect penalty: exactly one invalid IF/ID cycle after a redirect when stall_d=0.

Reset
REQ-032 On rst=0, immediately: pc_f=RESET_PC, pc_req=0, req_valid=0, skid_*=0, instr_d=0, pc_d=0, pc_plus_d=0, valid_d=0, counters=0, state=BOOT.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; first post-reset fetch address is RESET_PC.

Verification
REQ-034 Reset release, no stall, mem[i]=0x1000+i -> imem_addr 0,1,2...; valid_d first 1 two edges after release with instr_d=0x1000, pc_d=0, pc_plus_d=1; then 0x1001, 0x1002 consecutively.
REQ-035 stall_d high 3 cycles while instr_d=0x1003 -> IF/ID holds 0x1003; after release delivers 0x1004, 0x1005 with no gap, loss or duplicate.
REQ-036 redirect_e=1, target_e=0x0040 while stall_d=1 -> imem_addr=0x0040 that cycle, valid_d=0 next edge, then instr_d=mem[0x40], pc_d=0x0040; flush_cnt=1.
REQ-037 RESET_PC=0xFFFE, AW=16, STEP=1 -> pc_d sequence 0xFFFE, 0xFFFF, 0x0000; pc_plus_d of 0xFFFF is 0x0000.
REQ-038 CNT_W=4, 20 sequential fetches -> fetch_cnt saturates at 15.
REQ-039 rst pulsed low during STALL with skid_valid=1 -> valid_d=0 asynchronously; restart fetches from RESET_PC, skid contents never delivered.

Source files
------------

// File: rtl/fetch_stage_p.sv
// rtl/fetch_stage_p.sv - instruction fetch stage with IF/ID register, stall skid buffer and redirect handling
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   stall_d             decode cannot accept; IF/ID held
//   redirect_e          taken branch/jump from execute, target_e is its destination
//   imem_addr           combinational address to the synchronous instruction memory
//   imem_rdata          memory data for the address presented the previous cycle
//   instr_d, pc_d,      IF/ID register contents and valid flag
//   pc_plus_d, valid_d
//   fetch_cnt           saturating count of instructions delivered to decode
//   flush_cnt           saturating count of redirects taken
module fetch_stage_p #(
    parameter int              DW       = 16,
    parameter int              AW       = 16,
    parameter int              STEP     = 1,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_d,
    input  logic             redirect_e,
    input  logic [AW-1:0]    target_e,
    output logic [AW-1:0]    imem_addr,
    input  logic [DW-1:0]    imem_rdata,
    output logic [DW-1:0]    instr_d,
    output logic [AW-1:0]    pc_d,
    output logic [AW-1:0]    pc_plus_d,
    output logic             valid_d,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL} state_t;

    localparam logic [AW-1:0] W_STEP = AW'(STEP);

    state_t           r_state;
    state_t           w_state_next;

    logic [AW-1:0]    r_pc_f;
    logic [AW-1:0]    r_pc_req;
    logic             r_req_valid;
    logic [DW-1:0]    r_skid_instr;
    logic [AW-1:0]    r_skid_pc;
    logic             r_skid_valid;
    logic [DW-1:0]    r_instr_d;
    logic [AW-1:0]    r_pc_d;
    logic [AW-1:0]    r_pc_plus_d;
    logic             r_valid_d;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_fetch_inc;

    // A redirect must reach memory in the same cycle to keep the penalty at one bubble.
    assign imem_addr = redirect_e ? target_e : r_pc_f;

    always_comb begin
        w_state_next = r_state;
        w_fetch_inc  = 1'b0;
        if (redirect_e) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_BOOT:  w_state_next = S_RUN;
                S_RUN: begin
                    w_state_next = stall_d ? S_STALL : S_RUN;
                    w_fetch_inc  = !stall_d && r_req_valid;
                end
                S_STALL: begin
                    w_state_next = stall_d ? S_STALL : S_RUN;
                    w_fetch_inc  = !stall_d && r_skid_valid;
                end
                default: w_state_next = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_f       <= RESET_PC;
            r_pc_req     <= '0;
            r_req_valid  <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_instr_d    <= '0;
            r_pc_d       <= '0;
            r_pc_plus_d  <= '0;
            r_valid_d    <= 1'b0;
            r_fetch_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (redirect_e) begin
                // Whatever the memory returns this cycle belongs to the wrong path.
                r_valid_d    <= 1'b0;
                r_skid_valid <= 1'b0;
                r_pc_req     <= target_e;
                r_req_valid  <= 1'b1;
                r_pc_f       <= target_e + W_STEP;
                if (r_flush_cnt != {CNT_W{1'b1}}) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
            end else begin
                case (r_state)
                    S_BOOT: begin
                        r_pc_req    <= r_pc_f;
                        r_req_valid <= 1'b1;
                        r_pc_f      <= r_pc_f + W_STEP;
                    end
                    S_RUN: begin
                        if (!stall_d) begin
                            r_instr_d   <= imem_rdata;
                            r_pc_d      <= r_pc_req;
                            r_pc_plus_d <= r_pc_req + W_STEP;
                            r_valid_d   <= r_req_valid;
                            r_pc_req    <= r_pc_f;
                            r_req_valid <= 1'b1;
                            r_pc_f      <= r_pc_f + W_STEP;
                        end else begin
                            // Memory data only lives one cycle; park it so the stall loses nothing.
                            r_skid_instr <= imem_rdata;
                            r_skid_pc    <= r_pc_req;
                            r_skid_valid <= r_req_valid;
                            r_req_valid  <= 1'b0;
                        end
                    end
                    S_STALL: begin
                        if (!stall_d) begin
                            r_instr_d    <= r_skid_instr;
                            r_pc_d       <= r_skid_pc;
                            r_pc_plus_d  <= r_skid_pc + W_STEP;
                            r_valid_d    <= r_skid_valid;
                            r_skid_valid <= 1'b0;
                            r_pc_req     <= r_pc_f;
                            r_req_valid  <= 1'b1;
                            r_pc_f       <= r_pc_f + W_STEP;
                        end
                    end
                    default: ;
                endcase
                if (w_fetch_inc && (r_fetch_cnt != {CNT_W{1'b1}})) begin
                    r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign instr_d   = r_instr_d;
    assign pc_d      = r_pc_d;
    assign pc_plus_d = r_pc_plus_d;
    assign valid_d   = r_valid_d;
    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage_p.sv
// tb/tb_fetch_stage_p.sv - randomized scoreboard bench for fetch_stage_p
module tb_fetch_stage_p;

    localparam int            DW       = 16;
    localparam int            AW       = 16;
    localparam int            CNT_W    = 4;
    localparam logic [15:0]   RESET_PC = 16'hFFFE;
    localparam logic [3:0]    CNT_MAX  = 4'hF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             stall_d = 1'b0;
    logic             redirect_e = 1'b0;
    logic [AW-1:0]    target_e = '0;
    logic [AW-1:0]    imem_addr;
    logic [DW-1:0]    imem_rdata = '0;
    logic [DW-1:0]    instr_d;
    logic [AW-1:0]    pc_d;
    logic [AW-1:0]    pc_plus_d;
    logic             valid_d;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    fetch_stage_p #(
        .DW(DW), .AW(AW), .STEP(1), .RESET_PC(RESET_PC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall_d(stall_d), .redirect_e(redirect_e),
        .target_e(target_e), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus_d(pc_plus_d), .valid_d(valid_d),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a + 16'h1000;
    endfunction

    always @(posedge clk) imem_rdata <= memf(imem_addr);

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: inputs seen at a negedge are the ones the following posedge acts on.
    logic        p_rst = 1'b0;
    logic        p_stall = 1'b0;
    logic        p_redir = 1'b0;
    logic        p_boot = 1'b0;
    logic [15:0] p_instr = '0;
    logic [15:0] p_pc = '0;
    logic [15:0] p_pcp = '0;
    logic        p_valid = 1'b0;
    logic [3:0]  m_fetch = '0;
    logic [3:0]  m_flush = '0;

    always @(negedge clk) begin
        logic        cur_boot;
        logic [15:0] e;
        if (!rst) begin
            m_fetch = '0;
            m_flush = '0;
            chk(!valid_d && fetch_cnt == 0 && flush_cnt == 0, "reset_state",
                {valid_d, fetch_cnt, flush_cnt}, 0);
            p_rst = 1'b0;
        end else begin
            cur_boot = !p_rst;
            if (p_rst) begin
                if (p_redir) begin
                    chk(!valid_d, "redirect_bubble", valid_d, 0);
                    if (m_flush != CNT_MAX) m_flush = m_flush + 1;
                end else if (p_boot) begin
                    chk(!valid_d, "boot_invalid", valid_d, 0);
                end else if (p_stall) begin
                    chk(valid_d == p_valid && instr_d == p_instr && pc_d == p_pc && pc_plus_d == p_pcp,
                        "stall_hold", {valid_d, instr_d, pc_d}, {p_valid, p_instr, p_pc});
                end else begin
                    chk(valid_d, "no_gap_valid", valid_d, 1);
                    if (m_fetch != CNT_MAX) m_fetch = m_fetch + 1;
                end
                chk(fetch_cnt == m_fetch, "fetch_cnt", fetch_cnt, m_fetch);
                chk(flush_cnt == m_flush, "flush_cnt", flush_cnt, m_flush);
            end
            if (redirect_e) begin
                chk(imem_addr == target_e, "imem_addr_redirect", imem_addr, target_e);
            end else if (cur_boot) begin
                chk(imem_addr == RESET_PC, "imem_addr_boot", imem_addr, RESET_PC);
            end
            if (valid_d && !stall_d && !redirect_e) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "scoreboard_empty", pc_d, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(pc_d == e && instr_d == memf(e) && pc_plus_d == e + 16'd1, "delivered",
                        {instr_d, pc_d, pc_plus_d}, {memf(e), e, e + 16'd1});
                    if (exp_q.size() == 0) exp_q.push_back(e + 16'd1);
                end
            end
            p_rst   = 1'b1;
            p_stall = stall_d;
            p_redir = redirect_e;
            p_boot  = cur_boot;
        end
        p_instr = instr_d;
        p_pc    = pc_d;
        p_pcp   = pc_plus_d;
        p_valid = valid_d;
    end

    task automatic drive(input logic s, input logic r, input logic [15:0] t);
        @(posedge clk);
        #1;
        stall_d    = s;
        redirect_e = r;
        target_e   = t;
        if (r) begin
            exp_q.delete();
            exp_q.push_back(t);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        #1;
        chk(!valid_d && instr_d == 0 && pc_d == 0 && pc_plus_d == 0 && fetch_cnt == 0 && flush_cnt == 0,
            "async_reset", {valid_d, instr_d, pc_d, fetch_cnt, flush_cnt}, 0);
        stall_d    = 1'b0;
        redirect_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic random_cycles(input int n);
        logic        s;
        logic        r;
        logic [15:0] t;
        for (int i = 0; i < n; i++) begin
            s = ($urandom_range(0, 99) < 35);
            r = ($urandom_range(0, 99) < 7);
            t = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            drive(s, r, t);
        end
    endtask

    initial begin
        exp_q.push_back(RESET_PC);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, 16'h0040);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        random_cycles(300);
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        pulse_reset();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, '0);
        random_cycles(300);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
